// File: rtl/neopix_pkg.sv
// rtl/neopix_pkg.sv - shared types and constants for the NeoPixel frame controller
package neopix_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PIX,
        ST_WAIT_TX,
        ST_DRAIN
    } state_t;

    localparam logic [7:0] CMD_SHOW    = 8'hA5;
    localparam logic [7:0] CMD_CLR_ERR = 8'h5A;

    localparam int ERR_CMD   = 0;
    localparam int ERR_LEN   = 1;
    localparam int ERR_SHORT = 2;
    localparam int ERR_BUSY  = 3;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer, resets to the inactive (high) level
module sync_2ff (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta;

    // Two back-to-back flops; both come out of reset high so slave select reads inactive
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            meta <= 1'b1;
            q_o  <= 1'b1;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end

endmodule

// File: rtl/neopix_frame_ctrl.sv
// rtl/neopix_frame_ctrl.sv - parses SPI frames into pixel RAM writes and serializer start pulses
module neopix_frame_ctrl
    import neopix_pkg::*;
#(
    parameter int MAX_PIXELS = 64,
    parameter int ADDR_W     = $clog2(MAX_PIXELS)
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    input  logic              ssel_i,
    input  logic              tx_busy_i,
    output logic              pix_we_o,
    output logic [ADDR_W-1:0] pix_addr_o,
    output logic [23:0]       pix_data_o,
    output logic              tx_start_o,
    output logic [ADDR_W:0]   tx_count_o,
    output logic [3:0]        err_o
);

    localparam logic [7:0]    MAX_N   = 8'(MAX_PIXELS);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

    state_t            state;
    logic              ssel_sync;
    logic              active;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] pix_idx;
    logic [1:0]        phase;
    logic [15:0]       asm_q;
    logic              last_pix;

    sync_2ff u_ssel_sync (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .d_i      (ssel_i),
        .q_o      (ssel_sync)
    );

    assign active   = ~ssel_sync;
    assign last_pix = ({1'b0, pix_idx} == (len_q - LEN_ONE));

    // Frame FSM; a byte in the same cycle as an ssel deassert wins, the deassert is seen next cycle
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state      <= ST_IDLE;
            pix_we_o   <= 1'b0;
            pix_addr_o <= '0;
            pix_data_o <= '0;
            tx_start_o <= 1'b0;
            tx_count_o <= '0;
            err_o      <= '0;
            len_q      <= '0;
            pix_idx    <= '0;
            phase      <= '0;
            asm_q      <= '0;
        end else begin
            pix_we_o   <= 1'b0;
            tx_start_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (byte_valid_i && active) begin
                        if (byte_i == CMD_SHOW) begin
                            if (tx_busy_i) begin
                                err_o[ERR_BUSY] <= 1'b1;
                                state           <= ST_DRAIN;
                            end else begin
                                state <= ST_LEN;
                            end
                        end else if (byte_i == CMD_CLR_ERR) begin
                            err_o <= '0;
                            state <= ST_DRAIN;
                        end else begin
                            err_o[ERR_CMD] <= 1'b1;
                            state          <= ST_DRAIN;
                        end
                    end
                end
                ST_LEN: begin
                    if (byte_valid_i) begin
                        if (byte_i != 8'd0 && byte_i <= MAX_N) begin
                            len_q   <= (ADDR_W+1)'(byte_i);
                            pix_idx <= '0;
                            phase   <= '0;
                            state   <= ST_PIX;
                        end else begin
                            err_o[ERR_LEN] <= 1'b1;
                            state          <= ST_DRAIN;
                        end
                    end else if (!active) begin
                        err_o[ERR_SHORT] <= 1'b1;
                        state            <= ST_IDLE;
                    end
                end
                ST_PIX: begin
                    if (byte_valid_i) begin
                        asm_q <= {asm_q[7:0], byte_i};
                        if (phase == 2'd2) begin
                            phase      <= '0;
                            pix_we_o   <= 1'b1;
                            pix_addr_o <= pix_idx;
                            pix_data_o <= {asm_q, byte_i};
                            pix_idx    <= pix_idx + ADDR_W'(1'b1);
                            if (last_pix) begin
                                state <= ST_WAIT_TX;
                            end
                        end else begin
                            phase <= phase + 2'd1;
                        end
                    end else if (!active) begin
                        err_o[ERR_SHORT] <= 1'b1;
                        state            <= ST_IDLE;
                    end
                end
                ST_WAIT_TX: begin
                    if (!tx_busy_i) begin
                        tx_start_o <= 1'b1;
                        tx_count_o <= len_q;
                        state      <= active ? ST_DRAIN : ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (!active) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neopix_frame_ctrl.sv
// tb/tb_neopix_frame_ctrl.sv - randomized self-checking bench for neopix_frame_ctrl
module tb_neopix_frame_ctrl;

    localparam int MAXP = 64;
    localparam int AW   = 6;

    logic          clk = 1'b0;
    logic          reset_ni;
    logic [7:0]    byte_d;
    logic          byte_valid;
    logic          ssel;
    logic          tx_busy;
    logic          pix_we;
    logic [AW-1:0] pix_addr;
    logic [23:0]   pix_data;
    logic          tx_start;
    logic [AW:0]   tx_count;
    logic [3:0]    err;

    int n_pass = 0;
    int n_chk  = 0;

    logic [29:0] exp_wr_q[$];
    logic [29:0] got_wr_q[$];
    logic [6:0]  exp_st_q[$];
    logic [6:0]  got_st_q[$];
    logic [7:0]  frame_q[$];
    logic [3:0]  m_err;

    always #5 clk = ~clk;

    neopix_frame_ctrl #(.MAX_PIXELS(MAXP)) dut (
        .clk_i        (clk),
        .reset_ni     (reset_ni),
        .byte_i       (byte_d),
        .byte_valid_i (byte_valid),
        .ssel_i       (ssel),
        .tx_busy_i    (tx_busy),
        .pix_we_o     (pix_we),
        .pix_addr_o   (pix_addr),
        .pix_data_o   (pix_data),
        .tx_start_o   (tx_start),
        .tx_count_o   (tx_count),
        .err_o        (err)
    );

    task automatic chk(input string name, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Every write and start pulse must match the next outcome the frame model predicted
    always @(negedge clk) begin
        logic [29:0] w;
        logic [6:0]  s;
        if (reset_ni) begin
            if (pix_we) begin
                got_wr_q.push_back({pix_addr, pix_data});
                if (exp_wr_q.size() == 0) chk("unexpected_write", {pix_addr, pix_data}, 0);
                else begin
                    w = exp_wr_q.pop_front();
                    chk("write", {pix_addr, pix_data}, w);
                end
            end
            if (tx_start) begin
                got_st_q.push_back(tx_count);
                if (exp_st_q.size() == 0) chk("unexpected_start", tx_count, 0);
                else begin
                    s = exp_st_q.pop_front();
                    chk("start_count", tx_count, s);
                end
            end
        end
    end

    // Outcome of a whole frame (slave select released after the last byte sent)
    task automatic model_frame(input bit busy);
        int n;
        int full;
        if (frame_q.size() == 0) return;
        if (frame_q[0] == 8'hA5) begin
            if (busy) m_err[3] = 1'b1;
            else if (frame_q.size() < 2) m_err[2] = 1'b1;
            else begin
                n = frame_q[1];
                if (n == 0 || n > MAXP) m_err[1] = 1'b1;
                else begin
                    full = (frame_q.size() - 2) / 3;
                    if (full > n) full = n;
                    for (int i = 0; i < full; i++)
                        exp_wr_q.push_back({6'(i), frame_q[2+3*i], frame_q[3+3*i], frame_q[4+3*i]});
                    if (frame_q.size() >= 2 + 3 * n) exp_st_q.push_back(7'(n));
                    else m_err[2] = 1'b1;
                end
            end
        end else if (frame_q[0] == 8'h5A) begin
            m_err = 4'h0;
        end else begin
            m_err[0] = 1'b1;
        end
    endtask

    task automatic send_bytes(input int busy_after);
        for (int i = 0; i < frame_q.size(); i++) begin
            @(negedge clk);
            byte_d     = frame_q[i];
            byte_valid = 1'b1;
            @(negedge clk);
            byte_valid = 1'b0;
            byte_d     = 8'($urandom);
            if (i == busy_after) tx_busy = 1'b1;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic send_frame(input int busy_after);
        got_wr_q.delete();
        got_st_q.delete();
        ssel = 1'b0;
        repeat (3) @(negedge clk);
        model_frame(tx_busy);
        send_bytes(busy_after);
        ssel = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic end_check(input string name);
        chk({name, "_writes_left"}, exp_wr_q.size(), 0);
        chk({name, "_starts_left"}, exp_st_q.size(), 0);
        chk({name, "_err"}, err, m_err);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        int n;
        int cut;
        logic [7:0] c;
        reset_ni   = 1'b0;
        ssel       = 1'b1;
        tx_busy    = 1'b0;
        byte_valid = 1'b0;
        byte_d     = 8'h00;
        m_err      = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_we", pix_we, 0);
        chk("rst_addr", pix_addr, 0);
        chk("rst_data", pix_data, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_count", tx_count, 0);
        chk("rst_err", err, 0);
        reset_ni = 1'b1;
        repeat (2) @(negedge clk);

        // Basic two-pixel show
        frame_q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_frame(-1);
        end_check("two_pix");
        chk("two_pix_nwr", got_wr_q.size(), 2);
        if (got_wr_q.size() == 2) begin
            chk("two_pix_w0", got_wr_q[0], {6'd0, 24'h112233});
            chk("two_pix_w1", got_wr_q[1], {6'd1, 24'h445566});
        end
        chk("two_pix_nst", got_st_q.size(), 1);
        if (got_st_q.size() == 1) chk("two_pix_cnt", got_st_q[0], 2);
        chk("two_pix_err_lit", err, 4'b0000);

        // Bad command then clear
        frame_q = '{8'h7E, 8'h01, 8'h02, 8'h03};
        send_frame(-1);
        end_check("bad_cmd");
        chk("bad_cmd_lit", err, 4'b0001);
        chk("bad_cmd_nwr", got_wr_q.size(), 0);
        frame_q = '{8'h5A, 8'h00};
        send_frame(-1);
        end_check("clr");
        chk("clr_lit", err, 4'b0000);

        // Length boundaries
        frame_q = '{8'hA5, 8'h00, 8'h11, 8'h22, 8'h33};
        send_frame(-1);
        end_check("len0");
        frame_q = '{8'hA5, 8'(MAXP + 1), 8'h11, 8'h22, 8'h33};
        send_frame(-1);
        end_check("len_over");
        chk("len_lit", err, 4'b0010);
        chk("len_nst", got_st_q.size(), 0);
        frame_q = '{8'h5A};
        send_frame(-1);
        frame_q = '{8'hA5, 8'(MAXP)};
        for (int i = 0; i < 3 * MAXP; i++) frame_q.push_back(8'($urandom));
        send_frame(-1);
        end_check("len_max");
        if (got_st_q.size() == 1) chk("len_max_cnt", got_st_q[0], MAXP);
        else chk("len_max_nst", got_st_q.size(), 1);
        if (got_wr_q.size() == MAXP) chk("len_max_last_addr", got_wr_q[MAXP-1][29:24], MAXP - 1);

        // Truncated in PIX
        frame_q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(-1);
        end_check("short");
        chk("short_lit", err, 4'b0100);
        chk("short_nwr", got_wr_q.size(), 1);
        if (got_wr_q.size() == 1) chk("short_w0", got_wr_q[0], {6'd0, 24'h112233});
        chk("short_nst", got_st_q.size(), 0);
        frame_q = '{8'h5A};
        send_frame(-1);

        // Serializer busy after LEN: start held until it falls
        frame_q = '{8'hA5, 8'h01, 8'hAB, 8'hCD, 8'hEF};
        send_frame(1);
        repeat (10) @(negedge clk);
        chk("busy_hold_nst", got_st_q.size(), 0);
        tx_busy = 1'b0;
        @(negedge clk);
        chk("busy_release_start", tx_start, 1);
        @(negedge clk);
        end_check("busy_wait");
        if (got_st_q.size() == 1) chk("busy_wait_cnt", got_st_q[0], 1);
        tx_busy = 1'b1;
        frame_q = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03};
        send_frame(-1);
        tx_busy = 1'b0;
        end_check("busy_rej");
        chk("busy_rej_lit", err, 4'b1000);
        chk("busy_rej_nwr", got_wr_q.size(), 0);

        // Reset in the middle of PIX
        got_wr_q.delete();
        got_st_q.delete();
        ssel = 1'b0;
        repeat (3) @(negedge clk);
        frame_q = '{8'hA5, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40};
        model_frame(1'b0);
        send_bytes(-1);
        reset_ni = 1'b0;
        #1;
        chk("mid_rst_we", pix_we, 0);
        chk("mid_rst_addr", pix_addr, 0);
        chk("mid_rst_data", pix_data, 0);
        chk("mid_rst_count", tx_count, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_nwr", got_wr_q.size(), 1);
        exp_wr_q.delete();
        exp_st_q.delete();
        m_err = 4'h0;
        @(negedge clk);
        ssel = 1'b1;
        repeat (2) @(negedge clk);
        reset_ni = 1'b1;
        repeat (10) @(negedge clk);
        chk("mid_rst_no_start", got_st_q.size(), 0);
        frame_q = '{8'hA5, 8'h01, 8'h0F, 8'hF0, 8'h5A};
        send_frame(-1);
        end_check("after_rst");
        if (got_st_q.size() == 1) chk("after_rst_cnt", got_st_q[0], 1);

        // Random frames
        for (int f = 0; f < 40; f++) begin
            t = $urandom_range(0, 9);
            frame_q.delete();
            n = (t == 4) ? $urandom_range(1, MAXP) : $urandom_range(1, 8);
            case (t)
                0, 1, 2, 3, 4, 5: begin
                    frame_q.push_back(8'hA5);
                    frame_q.push_back(8'(n));
                    for (int i = 0; i < 3 * n; i++) frame_q.push_back(8'($urandom));
                    if (t == 5) begin
                        cut = $urandom_range(1, 2 + 3 * n - 1);
                        while (frame_q.size() > cut) void'(frame_q.pop_back());
                    end else begin
                        repeat ($urandom_range(0, 2)) frame_q.push_back(8'($urandom));
                    end
                end
                6: begin
                    c = 8'($urandom);
                    if (c == 8'hA5 || c == 8'h5A) c = 8'h00;
                    frame_q.push_back(c);
                    repeat ($urandom_range(0, 3)) frame_q.push_back(8'($urandom));
                end
                7: begin
                    frame_q.push_back(8'hA5);
                    frame_q.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXP + 1, 255)));
                    repeat ($urandom_range(0, 4)) frame_q.push_back(8'($urandom));
                end
                8: begin
                    frame_q.push_back(8'h5A);
                    repeat ($urandom_range(0, 3)) frame_q.push_back(8'($urandom));
                end
                default: begin
                    tx_busy = 1'b1;
                    frame_q = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03};
                end
            endcase
            send_frame(-1);
            tx_busy = 1'b0;
            end_check("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
